// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I load/store funct3 encodings
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - MEM-stage data memory access bus
//  address  byte address from the core
//  write_en store strobe
//  func3    RV32I funct3 of the load/store
//  data_in  right-aligned store data
//  data_out extended load result (combinational)
interface data_mem_if;

    logic [31:0] address;
    logic        write_en;
    logic [2:0]  func3;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output address, write_en, func3, data_in,
        input  data_out
    );

    modport slave (
        input  address, write_en, func3, data_in,
        output data_out
    );

endinterface

// File: rtl/data_mem_load_ext.sv
// rtl/data_mem_load_ext.sv - load lane select with sign/zero extension
//  word     stored 32-bit word at the addressed index
//  byte_sel address[1:0]
//  func3    load type
//  data_out extended load result
module data_mem_load_ext
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  func3,
    output logic [31:0] data_out
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] shifted;

    always_comb begin
        shifted   = word >> {byte_sel, 3'b000};
        lane_byte = shifted[7:0];
        // byte_sel[0] is ignored for halves: misaligned loads read the containing half
        lane_half = byte_sel[1] ? word[31:16] : word[15:0];
        case (func3)
            F3_B:    data_out = {{24{lane_byte[7]}}, lane_byte};
            F3_H:    data_out = {{16{lane_half[15]}}, lane_half};
            F3_W:    data_out = word;
            F3_BU:   data_out = {24'h0, lane_byte};
            F3_HU:   data_out = {16'h0, lane_half};
            default: data_out = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - RV32I data memory, synchronous byte-enabled stores, combinational loads
//  clk  rising-edge clock
//  rst  synchronous active-high reset, clears every word
//  bus  data_mem_if slave: address, write_en, func3, data_in in; data_out out
module data_mem
    import riscv_pkg::*;
#(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [3:0]        byte_en;
    logic [31:0]       wdata;
    logic              unused_addr_bits;

    // Upper address bits are dropped so the index wraps modulo DEPTH
    assign idx              = bus.address[ADDR_W+1:2];
    assign unused_addr_bits = &{1'b0, bus.address[31:ADDR_W+2]};

    // Store data is replicated across lanes; byte_en picks which lanes land
    always_comb begin
        byte_en = 4'b0000;
        wdata   = bus.data_in;
        case (bus.func3)
            F3_B: begin
                byte_en = 4'b0001 << bus.address[1:0];
                wdata   = {4{bus.data_in[7:0]}};
            end
            F3_H: begin
                byte_en = bus.address[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{bus.data_in[15:0]}};
            end
            F3_W: begin
                byte_en = 4'b1111;
            end
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (bus.write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    data_mem_load_ext u_load_ext (
        .word     (mem[idx]),
        .byte_sel (bus.address[1:0]),
        .func3    (bus.func3),
        .data_out (bus.data_out)
    );

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - self-checking bench for data_mem
module tb_data_mem;

    localparam int DEPTH = 64;

    typedef struct {
        bit          r;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] din;
        bit          chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    vec_t       vecs[$];
    logic [7:0] ref_mem [DEPTH*4];

    data_mem_if bus ();

    data_mem #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input bit r, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit chk, input logic [31:0] e, input string nm);
        vec_t v;
        v.r = r; v.we = we; v.f3 = f3; v.addr = a; v.din = d;
        v.chk = chk; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    // Drive one cycle at the falling edge, check data_out before the committing edge
    task automatic step(input vec_t v);
        @(negedge clk);
        rst          = v.r;
        bus.write_en = v.we;
        bus.func3    = v.f3;
        bus.address  = v.addr;
        bus.data_in  = v.din;
        #1;
        if (v.chk) begin
            n_vec++;
            if (bus.data_out !== v.exp) begin
                n_err++;
                $display("FAIL %s: addr=%h func3=%b data_out=%h expected=%h",
                         v.name, v.addr, v.f3, bus.data_out, v.exp);
            end
        end
    endtask

    function automatic int byte_addr(input logic [31:0] a);
        return int'(a % (DEPTH * 4));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int          b;
        int          h;
        int          w;
        logic [15:0] hv;
        b  = byte_addr(a);
        h  = b - (b % 2);
        w  = b - (b % 4);
        hv = {ref_mem[h+1], ref_mem[h]};
        case (f3)
            3'd0:    return 32'($signed(ref_mem[b]));
            3'd1:    return 32'($signed(hv));
            3'd2:    return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
            3'd4:    return {24'h0, ref_mem[b]};
            3'd5:    return {16'h0, hv};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int b;
        int h;
        int w;
        b = byte_addr(a);
        h = b - (b % 2);
        w = b - (b % 4);
        case (f3)
            3'd0: ref_mem[b] = d[7:0];
            3'd1: begin
                ref_mem[h]   = d[7:0];
                ref_mem[h+1] = d[15:8];
            end
            3'd2: for (int k = 0; k < 4; k++) ref_mem[w+k] = d[8*k +: 8];
            default: ;
        endcase
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.write_en = 1'b0;
        bus.func3    = 3'b010;
        bus.address  = 32'h0;
        bus.data_in  = 32'h0;

        //   rst we  f3      addr         din           chk exp
        add(1, 1, 3'b010, 32'h04,      32'hDEADBEEF, 0, 32'h0,        "reset_write");
        add(0, 0, 3'b010, 32'h04,      32'h0,        1, 32'h00000000, "reset_lw4");
        add(0, 0, 3'b010, 32'h00,      32'h0,        1, 32'h00000000, "reset_lw0");
        add(0, 1, 3'b010, 32'h04,      32'hAABBCCDD, 1, 32'h00000000, "sw_pre_edge");
        add(0, 0, 3'b010, 32'h04,      32'h0,        1, 32'hAABBCCDD, "lw4");
        add(0, 0, 3'b010, 32'h00,      32'h0,        1, 32'h00000000, "lw0");
        add(0, 1, 3'b000, 32'h05,      32'h000000EE, 1, 32'hFFFFFFCC, "sb_pre_edge");
        add(0, 0, 3'b010, 32'h04,      32'h0,        1, 32'hAABBEEDD, "lw_after_sb");
        add(0, 0, 3'b000, 32'h05,      32'h0,        1, 32'hFFFFFFEE, "lb5");
        add(0, 0, 3'b100, 32'h05,      32'h0,        1, 32'h000000EE, "lbu5");
        add(0, 0, 3'b000, 32'h04,      32'h0,        1, 32'hFFFFFFDD, "lb4");
        add(0, 1, 3'b001, 32'h06,      32'h00001234, 1, 32'hFFFFAABB, "sh_pre_edge");
        add(0, 0, 3'b010, 32'h04,      32'h0,        1, 32'h1234EEDD, "lw_after_sh");
        add(0, 0, 3'b001, 32'h06,      32'h0,        1, 32'h00001234, "lh6");
        add(0, 0, 3'b101, 32'h06,      32'h0,        1, 32'h00001234, "lhu6");
        add(0, 1, 3'b001, 32'h04,      32'h00008001, 1, 32'hFFFFEEDD, "sh4_pre_edge");
        add(0, 0, 3'b001, 32'h04,      32'h0,        1, 32'hFFFF8001, "lh4");
        add(0, 0, 3'b101, 32'h04,      32'h0,        1, 32'h00008001, "lhu4");
        add(0, 0, 3'b010, 32'h04,      32'hDEADBEEF, 1, 32'h12348001, "we0_sw");
        add(0, 0, 3'b010, 32'h04,      32'h0,        1, 32'h12348001, "we0_unchanged");
        add(0, 1, 3'b011, 32'h04,      32'hFFFFFFFF, 1, 32'h00000000, "f3_011_read");
        add(0, 0, 3'b010, 32'h04,      32'h0,        1, 32'h12348001, "f3_011_no_write");
        add(0, 0, 3'b110, 32'h04,      32'h0,        1, 32'h00000000, "f3_110_read");
        add(0, 0, 3'b111, 32'h04,      32'h0,        1, 32'h00000000, "f3_111_read");
        add(0, 0, 3'b000, 32'h07,      32'h0,        1, 32'h00000012, "lb7");
        add(0, 0, 3'b001, 32'h05,      32'h0,        1, 32'hFFFF8001, "lh_misaligned");
        add(0, 1, 3'b001, 32'h07,      32'h0000ABCD, 1, 32'h00001234, "sh_misaligned");
        add(0, 0, 3'b010, 32'h04,      32'h0,        1, 32'hABCD8001, "lw_after_sh7");
        add(0, 1, 3'b010, DEPTH*4 + 8, 32'h5A5A1234, 1, 32'h00000000, "sw_wrap_pre");
        add(0, 0, 3'b010, 32'h08,      32'h0,        1, 32'h5A5A1234, "lw_wrap");
        add(1, 1, 3'b010, 32'h08,      32'hFFFFFFFF, 1, 32'h5A5A1234, "rst_pre_edge");
        add(0, 0, 3'b010, 32'h08,      32'h0,        1, 32'h00000000, "rst_lw8");
        add(0, 0, 3'b010, 32'h04,      32'h0,        1, 32'h00000000, "rst_lw4");

        foreach (vecs[i]) step(vecs[i]);

        // Table ends with memory cleared by reset
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h0;

        for (int i = 0; i < 800; i++) begin
            vec_t rv;
            rv.r    = ($urandom_range(0, 63) == 0);
            rv.we   = 1'($urandom_range(0, 1));
            rv.f3   = 3'($urandom_range(0, 7));
            rv.addr = $urandom & 32'hFFFFFF1F;
            rv.din  = $urandom;
            rv.chk  = 1;
            rv.exp  = model_load(rv.addr, rv.f3);
            rv.name = "random";
            step(rv);
            if (rv.r) begin
                for (int k = 0; k < DEPTH*4; k++) ref_mem[k] = 8'h0;
            end else if (rv.we) begin
                model_store(rv.addr, rv.f3, rv.din);
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
